// File: rtl/mm2s_128.sv
`default_nettype none
// ============================================================================
//  Module      : mm2s_128
//  Description : Memory-to-stream DMA surrogate. Reads ceil(byte_len/16)
//                128-bit BRAM words from base and emits them as AXI4-Stream
//                with TLAST/TKEEP through a credit-managed output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm2s_128 #(
    parameter int ADDR_W     = 12,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       byte_len,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [127:0]      rd_data,
    output logic [127:0]      m_tdata,
    output logic [15:0]       m_tkeep,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);

    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(FIFO_DEPTH);
    localparam logic [15:0]     c_KEEP_ALL = 16'hFFFF;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              r_rd_last;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [28:0]       r_reads_left;
    logic [15:0]       r_last_keep;
    logic [c_CW-1:0]   r_outstanding;
    logic [RD_LAT-1:0] r_pv;
    logic [RD_LAT-1:0] r_pl;

    logic [127:0]      r_mem_data [FIFO_DEPTH];
    logic [15:0]       r_mem_keep [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_tvalid;
    logic [127:0]      r_tdata;
    logic [15:0]       r_tkeep;
    logic              r_tlast;

    logic [28:0]       w_beats;
    logic [15:0]       w_last_keep;
    logic              w_launch;
    logic              w_zero_len;
    logic              w_pop;
    logic              w_issue;
    logic              w_finish;
    logic [28:0]       w_reads_left_nxt;
    logic              w_push;
    logic              w_push_last;
    logic [15:0]       w_push_keep;
    logic [c_CW-1:0]   w_count_nxt;
    logic [c_CW-1:0]   w_count_after_pop;
    logic [c_PW-1:0]   w_rd_ptr_nxt;
    logic [127:0]      w_head_data;
    logic [15:0]       w_head_keep;
    logic              w_head_last;

    assign w_beats     = 29'(({1'b0, byte_len} + 33'd15) >> 4);
    assign w_last_keep = (byte_len[3:0] == 4'd0) ? c_KEEP_ALL
                                                 : (16'h1 << byte_len[3:0]) - 16'h1;
    assign w_launch    = (r_state == c_IDLE) && start && (byte_len != 32'd0);
    assign w_zero_len  = (r_state == c_IDLE) && start && (byte_len == 32'd0);
    assign w_pop       = r_tvalid && m_tready;
    assign w_finish    = w_pop && r_tlast && (r_state != c_IDLE);

    // Credits cover FIFO entries plus every read issued or about to be issued;
    // a pop this cycle frees its slot immediately so the stream has no bubbles.
    assign w_issue = (r_state == c_RUN) && (r_reads_left != 29'd0) &&
                     ((r_outstanding - c_CW'(w_pop)) < c_DEPTH);
    assign w_reads_left_nxt = r_reads_left - 29'(w_issue);

    assign w_push      = r_pv[RD_LAT-1];
    assign w_push_last = r_pl[RD_LAT-1];
    assign w_push_keep = w_push_last ? r_last_keep : c_KEEP_ALL;

    assign w_count_nxt       = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_count_after_pop = r_count - c_CW'(w_pop);
    assign w_rd_ptr_nxt      = r_rd_ptr + c_PW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_launch) w_state_nxt = c_RUN;
            end
            c_RUN: begin
                if (w_finish)                       w_state_nxt = c_IDLE;
                else if (w_reads_left_nxt == 29'd0) w_state_nxt = c_DRAIN;
            end
            c_DRAIN: begin
                if (w_finish) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Next head of the FIFO: the incoming word if the FIFO would otherwise be empty.
    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_keep = r_mem_keep[w_rd_ptr_nxt];
        w_head_last = r_mem_last[w_rd_ptr_nxt];
        if (w_count_after_pop == '0) begin
            w_head_data = rd_data;
            w_head_keep = w_push_keep;
            w_head_last = w_push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_addr     <= '0;
            r_reads_left  <= '0;
            r_last_keep   <= c_KEEP_ALL;
            r_outstanding <= '0;
            r_pv          <= '0;
            r_pl          <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tlast       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_zero_len || w_finish;
            if (w_launch)      r_busy <= 1'b1;
            else if (w_finish) r_busy <= 1'b0;

            if (w_launch) begin
                r_rd_en      <= 1'b1;
                r_rd_last    <= (w_beats == 29'd1);
                r_rd_addr    <= base;
                r_reads_left <= w_beats - 29'd1;
                r_last_keep  <= w_last_keep;
            end else begin
                if (r_rd_en) r_rd_addr <= r_rd_addr + 1'b1;
                r_rd_en      <= w_issue;
                r_reads_left <= w_reads_left_nxt;
                if (w_issue) r_rd_last <= (r_reads_left == 29'd1);
            end
            r_outstanding <= r_outstanding + c_CW'(w_launch || w_issue) - c_CW'(w_pop);

            r_pv[0] <= r_rd_en;
            r_pl[0] <= r_rd_en && r_rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_tvalid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_tdata <= w_head_data;
                r_tkeep <= w_head_keep;
                r_tlast <= w_head_last;
            end else begin
                r_tdata <= '0;
                r_tkeep <= '0;
                r_tlast <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= rd_data;
            r_mem_keep[r_wr_ptr] <= w_push_keep;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign m_tdata  = r_tdata;
    assign m_tkeep  = r_tkeep;
    assign m_tvalid = r_tvalid;
    assign m_tlast  = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_mm2s_128.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm2s_128
//  Description : Self-checking bench for mm2s_128; instance 0 uses RD_LAT=1,
//                instance 1 uses RD_LAT=2, each with its own BRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm2s_128;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_s [2];
    logic [31:0] len_s   [2];
    logic [11:0] base_s  [2];
    logic        ready_s [2];
    logic [31:0] salt    [2];

    wire         busy_w   [2];
    wire         done_w   [2];
    wire         rd_en_w  [2];
    wire [11:0]  rd_addr_w[2];
    wire [127:0] rd_data_w[2];
    wire [127:0] tdata_w  [2];
    wire [15:0]  tkeep_w  [2];
    wire         tvalid_w [2];
    wire         tlast_w  [2];

    int n_cmp = 0;
    int n_bad = 0;
    int beats_seen [2];
    logic [144:0] exp_q  [2][$];
    logic [11:0]  addr_q [2][$];

    function automatic logic [127:0] bram_word(input logic [31:0] s, input logic [11:0] a);
        return {s, 20'd0, a, s ^ 32'h5A5A_5A5A, a, 20'hABCDE};
    endfunction

    function automatic logic [15:0] exp_keep(input logic [31:0] len, input int i);
        logic [31:0] rem;
        logic [16:0] k;
        rem = len - 32'(i * 16);
        if (rem >= 32'd16) return 16'hFFFF;
        k = (17'd1 << rem[4:0]) - 17'd1;
        return k[15:0];
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_side
        logic [11:0]  a1, a2;
        logic         e1, e2;
        logic         stall;
        logic [144:0] held;
        int           issued, popped;

        mm2s_128 #(.ADDR_W(12), .RD_LAT(g + 1), .FIFO_DEPTH(DEPTH)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_s[g]),
            .byte_len (len_s[g]),
            .base     (base_s[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .rd_en    (rd_en_w[g]),
            .rd_addr  (rd_addr_w[g]),
            .rd_data  (rd_data_w[g]),
            .m_tdata  (tdata_w[g]),
            .m_tkeep  (tkeep_w[g]),
            .m_tvalid (tvalid_w[g]),
            .m_tready (ready_s[g]),
            .m_tlast  (tlast_w[g])
        );

        always @(posedge clk) begin
            a1 <= rd_addr_w[g];
            e1 <= rd_en_w[g] && !rst;
            a2 <= a1;
            e2 <= e1;
        end
        assign rd_data_w[g] = ((g == 0) ? e1 : e2) ? bram_word(salt[g], (g == 0) ? a1 : a2)
                                                   : {4{32'hDEAD_BEEF}};

        always @(negedge clk) begin
            if (rst) begin
                exp_q[g].delete();
                addr_q[g].delete();
                issued = 0;
                popped = 0;
                stall = 1'b0;
                beats_seen[g] = 0;
            end else begin
                if (rd_en_w[g]) begin
                    issued++;
                    if (addr_q[g].size() == 0) chk($sformatf("spurious_rd_d%0d", g), 192'(rd_en_w[g]), 192'd0);
                    else chk($sformatf("rd_addr_d%0d", g), 192'(rd_addr_w[g]), 192'(addr_q[g].pop_front()));
                end
                if (stall)
                    chk($sformatf("stall_hold_d%0d", g), {tvalid_w[g], tdata_w[g], tkeep_w[g], tlast_w[g]},
                        {1'b1, held});
                if (tvalid_w[g] && ready_s[g]) begin
                    popped++;
                    beats_seen[g]++;
                    if (exp_q[g].size() == 0) chk($sformatf("spurious_beat_d%0d", g), 192'(tvalid_w[g]), 192'd0);
                    else chk($sformatf("beat_d%0d", g), {tdata_w[g], tkeep_w[g], tlast_w[g]}, 192'(exp_q[g].pop_front()));
                end
                chk($sformatf("credit_d%0d", g), 192'((issued - popped) <= DEPTH), 192'd1);
                stall = tvalid_w[g] && !ready_s[g];
                held  = {tdata_w[g], tkeep_w[g], tlast_w[g]};
            end
        end
    end

    // mode 0: tready high; mode 1: low 10 cycles then random. poke pulses start mid-transfer.
    task automatic run(input int d, input string name, input logic [11:0] b, input logic [31:0] len,
                       input int mode, input bit timing, input bit poke);
        int beats, first_rd, first_v, done_cyc, nbeats, any_busy, any_valid;
        logic busy_at_done;
        beats = int'((len + 32'd15) >> 4);
        first_rd = -1; first_v = -1; done_cyc = -1; nbeats = 0; any_busy = 0; any_valid = 0;
        busy_at_done = 1'b1;
        salt[d] = $urandom;
        for (int i = 0; i < beats; i++) begin
            logic [11:0] a;
            a = b + 12'(i);
            addr_q[d].push_back(a);
            exp_q[d].push_back({bram_word(salt[d], a), exp_keep(len, i), i == beats - 1});
        end
        @(posedge clk); #1;
        start_s[d] = 1'b1; len_s[d] = len; base_s[d] = b;
        ready_s[d] = (mode == 0);
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            start_s[d] = poke && (cyc == 3);
            if (poke && cyc == 3) begin len_s[d] = 32'd16; base_s[d] = 12'h777; end
            if (mode == 1) ready_s[d] = (cyc > 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (rd_en_w[d] && first_rd < 0) first_rd = cyc;
            if (tvalid_w[d] && first_v < 0) first_v = cyc;
            if (tvalid_w[d] && ready_s[d]) nbeats++;
            any_busy  += int'(busy_w[d]);
            any_valid += int'(tvalid_w[d]);
            if (done_w[d]) begin done_cyc = cyc; busy_at_done = busy_w[d]; end
        end
        chk({name, "_done_seen"}, 192'(done_cyc >= 0), 192'd1);
        chk({name, "_beats"}, 192'(nbeats), 192'(beats));
        chk({name, "_sb_empty"}, 192'(exp_q[d].size() + addr_q[d].size()), 192'd0);
        chk({name, "_busy_at_done"}, 192'(busy_at_done), 192'd0);
        if (beats == 0) begin
            chk({name, "_done_cycle"}, 192'(done_cyc), 192'd1);
            chk({name, "_never_busy"}, 192'(any_busy), 192'd0);
            chk({name, "_never_valid"}, 192'(any_valid), 192'd0);
        end else if (timing) begin
            chk({name, "_first_rd"}, 192'(first_rd), 192'd1);
            chk({name, "_first_valid"}, 192'(first_v), 192'(2 + d + 1));
            chk({name, "_done_cycle"}, 192'(done_cyc), 192'(2 + d + 1 + beats));
        end
        @(posedge clk);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 192'({done_w[d], busy_w[d]}), 192'd0);
        ready_s[d] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt, done_cnt;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; len_s[d] = '0; base_s[d] = '0; ready_s[d] = 1'b1; salt[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_state_d%0d", d),
                192'({busy_w[d], done_w[d], rd_en_w[d], rd_addr_w[d], tvalid_w[d], tlast_w[d], tkeep_w[d], tdata_w[d]}),
                192'd0);

        run(0, "T1",  12'h010, 32'd64,  0, 1'b1, 1'b0);
        run(0, "T2",  12'h020, 32'd40,  0, 1'b1, 1'b1);
        run(0, "T3",  12'h040, 32'd128, 1, 1'b0, 1'b0);
        run(0, "T4",  12'h050, 32'd0,   0, 1'b1, 1'b0);
        run(0, "T5",  12'hFFE, 32'd64,  0, 1'b1, 1'b0);

        salt[0] = $urandom;
        for (int i = 0; i < 8; i++) begin
            logic [11:0] a;
            a = 12'h100 + 12'(i);
            addr_q[0].push_back(a);
            exp_q[0].push_back({bram_word(salt[0], a), 16'hFFFF, i == 7});
        end
        @(posedge clk); #1;
        start_s[0] = 1'b1; len_s[0] = 32'd128; base_s[0] = 12'h100; ready_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_cnt = 0;
        while (beats_seen[0] < 2 && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("T6_two_beats", 192'(beats_seen[0] >= 2), 192'd1);
        @(posedge clk); #1;
        rst = 1'b1; ready_s[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ready_s[0] = 1'b1;
        @(negedge clk);
        chk("T6_outputs_reset",
            192'({busy_w[0], done_w[0], rd_en_w[0], rd_addr_w[0], tvalid_w[0], tlast_w[0], tkeep_w[0], tdata_w[0]}),
            192'd0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            done_cnt += int'(done_w[0]);
        end
        chk("T6_no_done", 192'(done_cnt), 192'd0);
        run(0, "T6_fresh", 12'h200, 32'd32, 0, 1'b1, 1'b0);

        run(1, "T1_lat2", 12'h010, 32'd64,  0, 1'b1, 1'b0);
        run(1, "T3_lat2", 12'h300, 32'd128, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
